serial_tx_arb: RTL and testbench

SERIAL_TX_ARB -- requirements
Module: serial_tx_arb

---
 rtl/serial_tx_arb_pkg.sv | 23 ++
 rtl/serial_tx_arb_if.sv | 26 ++
 rtl/serial_fifo.sv | 53 +++++
 rtl/serial_tx_arb.sv | 113 +++++++++++
 tb/tb_serial_tx_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_tx_arb_pkg.sv
// Shared types and constants for the serial transmit blocks.
// No logic; imported by the arbiter, its FIFO and its interface.
package serial_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_t;

   // Bit 0 is the MSB, matching the CPU accumulator numbering.
   typedef logic [0:7] char_t;

   localparam int          FIFO_DEPTH_DEF = 4;
   localparam logic [15:0] TIMEOUT_DEF    = 16'd50000;

   // Teleprinter IOT opcodes, decoded upstream into valid0 and clear_flag.
   localparam logic [11:0] IOT_TSF = 12'o6041;
   localparam logic [11:0] IOT_TCF = 12'o6042;
   localparam logic [11:0] IOT_TPC = 12'o6044;
   localparam logic [11:0] IOT_TLS = 12'o6046;

endpackage

// File: rtl/serial_tx_arb_if.sv
// Character handshake bundle between the two requesters, the arbiter and the UART.
// slave = arbiter side, master = requester/transmitter side.
interface serial_tx_arb_if;
   import serial_tx_arb_pkg::*;

   logic  valid0;
   char_t char0;
   logic  ready0;
   logic  valid1;
   char_t char1;
   logic  ready1;
   char_t tx_char;
   logic  tx_load;
   logic  tx_done;

   modport master (
      output valid0, char0, valid1, char1, tx_done,
      input  ready0, ready1, tx_char, tx_load
   );

   modport slave (
      input  valid0, char0, valid1, char1, tx_done,
      output ready0, ready1, tx_char, tx_load
   );

endinterface

// File: rtl/serial_fifo.sv
// Pointer-based character FIFO with occupancy count; head visible combinationally.
// Write-to-read latency 1 cycle; pushes are dropped when full, flush beats push and pop.
module serial_fifo
   import serial_tx_arb_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  char_t      push_dat,
   input  logic       pop,
   output char_t      head_dat,
   output logic [4:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   char_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push  = push & ~flush & (count < 5'(DEPTH));
   assign do_pop   = pop & ~flush & (count != '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + 5'(do_push) - 5'(do_pop);
      end
   end

endmodule

// File: rtl/serial_tx_arb.sv
// Round-robin arbiter feeding one UART from the CPU printer FIFO and the monitor port.
// Grant to tx_load 1 cycle; one character outstanding until tx_done or watchdog timeout.
module serial_tx_arb
   import serial_tx_arb_pkg::*;
#(
   parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter logic [15:0] TIMEOUT    = TIMEOUT_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic           clear_flag,
   serial_tx_arb_if.slave bus,
   output logic           printer_flag,
   output logic [4:0]     fifo_count,
   output logic           timeout_err
);

   arb_state_t  state;
   logic        gnt1;
   logic        last_gnt1;
   logic        pop_q;
   logic        tx_load_q;
   logic        ready1_q;
   char_t       tx_char_q;
   char_t       head;
   logic [15:0] wdog;
   logic        req0;
   logic        req1;
   logic        pick1;
   logic        push;

   assign req0       = (fifo_count != '0);
   assign req1       = bus.valid1;
   // Monitor wins when alone, or when the FIFO was the last one served.
   assign pick1      = req1 & (~req0 | ~last_gnt1);
   assign bus.ready0 = (fifo_count < 5'(FIFO_DEPTH));
   assign push       = bus.valid0 & bus.ready0;

   assign bus.tx_char = tx_char_q;
   assign bus.tx_load = tx_load_q;
   assign bus.ready1  = ready1_q;

   serial_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .push     (push),
      .push_dat (bus.char0),
      .pop      (pop_q),
      .head_dat (head),
      .count    (fifo_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         gnt1         <= 1'b0;
         last_gnt1    <= 1'b1;
         tx_char_q    <= '0;
         tx_load_q    <= 1'b0;
         ready1_q     <= 1'b0;
         pop_q        <= 1'b0;
         wdog         <= '0;
         printer_flag <= 1'b0;
         timeout_err  <= 1'b0;
      end else if (flush) begin
         state        <= ST_IDLE;
         tx_load_q    <= 1'b0;
         ready1_q     <= 1'b0;
         pop_q        <= 1'b0;
         wdog         <= '0;
         printer_flag <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         // A set from tx_done below overrides this clear.
         if (clear_flag) printer_flag <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req0 || req1) begin
                  state     <= ST_LOAD;
                  gnt1      <= pick1;
                  last_gnt1 <= pick1;
                  tx_char_q <= pick1 ? bus.char1 : head;
                  tx_load_q <= 1'b1;
                  ready1_q  <= pick1;
                  pop_q     <= ~pick1;
               end
            end
            ST_LOAD: begin
               state     <= ST_WAIT;
               tx_load_q <= 1'b0;
               ready1_q  <= 1'b0;
               pop_q     <= 1'b0;
               wdog      <= '0;
            end
            ST_WAIT: begin
               if (bus.tx_done) begin
                  state <= ST_IDLE;
                  if (!gnt1) printer_flag <= 1'b1;
               end else if (wdog == TIMEOUT - 16'd1) begin
                  state       <= ST_IDLE;
                  timeout_err <= 1'b1;
               end else begin
                  wdog <= wdog + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_arb.sv
// Bench for serial_tx_arb: reset values, a cycle table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_serial_tx_arb;
   import serial_tx_arb_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 100;

   logic       clk;
   logic       reset;
   logic       flush;
   logic       clear_flag;
   logic       printer_flag;
   logic       timeout_err;
   logic [4:0] fifo_count;

   serial_tx_arb_if bus();

   serial_tx_arb #(.FIFO_DEPTH(DEPTH), .TIMEOUT(16'(TMO))) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .clear_flag   (clear_flag),
      .bus          (bus),
      .printer_flag (printer_flag),
      .fifo_count   (fifo_count),
      .timeout_err  (timeout_err)
   );

   int checks = 0;
   int errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 1 ms");
      $fatal(1, "bench time limit");
   end

   typedef struct {
      logic       v0;
      logic [7:0] c0;
      logic       done;
      logic       clr;
      logic       e_rdy0;
      logic [4:0] e_cnt;
      logic       e_load;
      logic [7:0] e_char;
      logic       e_pf;
   } vec_t;

   vec_t       vt[24];
   logic [7:0] push_q[$];
   logic [7:0] ld_char[8];
   logic       ld_pf[8];
   int         n_loads;
   int         n_rdy1;
   int         n_double;

   // Reference model state
   logic [7:0] m_q[$];
   int         m_age;
   logic       m_g1;
   logic       m_last1;
   logic       m_pf;
   logic       m_te;
   logic [7:0] m_char;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      flush      = 1'b0;
      clear_flag = 1'b0;
      bus.valid0 = 1'b0;
      bus.char0  = '0;
      bus.valid1 = 1'b0;
      bus.char1  = '0;
      bus.tx_done = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   function automatic vec_t mk(logic v0, logic [7:0] c0, logic done, logic clr,
                               logic e_rdy0, logic [4:0] e_cnt, logic e_load,
                               logic [7:0] e_char, logic e_pf);
      vec_t v;
      v.v0 = v0; v.c0 = c0; v.done = done; v.clr = clr;
      v.e_rdy0 = e_rdy0; v.e_cnt = e_cnt; v.e_load = e_load; v.e_char = e_char; v.e_pf = e_pf;
      return v;
   endfunction

   // Runs the bus for max_cyc cycles: feeds push_q into requester 0, raises valid1 at
   // cycle v1_iter, answers every tx_load with tx_done dly cycles later, logs the loads.
   task automatic serve(input int max_cyc, input int dly, input int v1_iter, input logic [7:0] v1_char);
      int   since;
      logic prev;
      since = -1;
      prev  = 1'b0;
      n_loads = 0; n_rdy1 = 0; n_double = 0;
      for (int c = 0; c < max_cyc; c++) begin
         if (c == v1_iter) begin
            bus.valid1 = 1'b1;
            bus.char1  = v1_char;
         end
         if (push_q.size() > 0 && bus.ready0) begin
            bus.valid0 = 1'b1;
            bus.char0  = push_q.pop_front();
         end else begin
            bus.valid0 = 1'b0;
         end
         if (since >= 0) since++;
         bus.tx_done = (since == dly);
         if (since == dly) since = -1;
         tick();
         if (bus.ready1) begin
            n_rdy1++;
            chk("ready1_during_load", 32'(bus.tx_load), 32'(1));
            chk("ready1_char", 32'(bus.tx_char), 32'(v1_char));
            bus.valid1 = 1'b0;
         end
         if (bus.tx_load) begin
            if (prev) n_double++;
            if (n_loads < 8) begin
               ld_char[n_loads] = bus.tx_char;
               ld_pf[n_loads]   = printer_flag;
            end
            n_loads++;
            since = 0;
         end
         prev = bus.tx_load;
      end
      bus.valid0  = 1'b0;
      bus.tx_done = 1'b0;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_age = -1; m_g1 = 1'b0; m_last1 = 1'b1;
      m_pf = 1'b0; m_te = 1'b0; m_char = '0;
   endtask

   // Advances the model across one clock edge using the inputs currently driven.
   task automatic model_step();
      logic push;
      logic pop;
      push = bus.valid0 && (m_q.size() < DEPTH);
      pop  = 1'b0;
      if (flush) begin
         m_q.delete();
         m_pf = 1'b0; m_te = 1'b0; m_age = -1;
      end else begin
         if (clear_flag) m_pf = 1'b0;
         if (m_age < 0) begin
            if (m_q.size() > 0 || bus.valid1) begin
               if (m_q.size() > 0 && bus.valid1) m_g1 = (m_last1 == 1'b0);
               else                              m_g1 = bus.valid1;
               m_char  = m_g1 ? bus.char1 : m_q[0];
               m_last1 = m_g1;
               m_age   = 0;
            end
         end else if (m_age == 0) begin
            pop   = !m_g1;
            m_age = 1;
         end else if (bus.tx_done) begin
            m_age = -1;
            if (!m_g1) m_pf = 1'b1;
         end else if (m_age == TMO) begin
            m_age = -1;
            m_te  = 1'b1;
         end else begin
            m_age++;
         end
         if (pop)  m_q.delete(0);
         if (push) m_q.push_back(bus.char0);
      end
   endtask

   initial begin
      int  loads;
      int  quiet;
      logic v1_on;

      // ---------------- reset state ----------------
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      chk("rst_ready0",       32'(bus.ready0),   32'(1));
      chk("rst_ready1",       32'(bus.ready1),   32'(0));
      chk("rst_tx_load",      32'(bus.tx_load),  32'(0));
      chk("rst_tx_char",      32'(bus.tx_char),  32'(0));
      chk("rst_fifo_count",   32'(fifo_count),   32'(0));
      chk("rst_printer_flag", 32'(printer_flag), 32'(0));
      chk("rst_timeout_err",  32'(timeout_err),  32'(0));
      reset = 1'b1;
      tick();

      // ---------------- cycle table: fill, full stall, set-vs-clear, drain ----------------
      vt[0]  = mk(1, 8'hA0, 0, 0,  1, 5'd1, 0, 8'h00, 0);
      vt[1]  = mk(1, 8'hA1, 0, 0,  1, 5'd2, 1, 8'hA0, 0);
      vt[2]  = mk(1, 8'hA2, 0, 0,  1, 5'd2, 0, 8'h00, 0);
      vt[3]  = mk(1, 8'hA3, 0, 0,  1, 5'd3, 0, 8'h00, 0);
      vt[4]  = mk(1, 8'hA4, 0, 0,  0, 5'd4, 0, 8'h00, 0);
      vt[5]  = mk(1, 8'hA5, 0, 0,  0, 5'd4, 0, 8'h00, 0);
      vt[6]  = mk(1, 8'hA5, 1, 1,  0, 5'd4, 0, 8'h00, 1);
      vt[7]  = mk(1, 8'hA5, 0, 1,  0, 5'd4, 1, 8'hA1, 0);
      vt[8]  = mk(1, 8'hA5, 0, 0,  1, 5'd3, 0, 8'h00, 0);
      vt[9]  = mk(1, 8'hA5, 0, 0,  0, 5'd4, 0, 8'h00, 0);
      vt[10] = mk(0, 8'h00, 1, 0,  0, 5'd4, 0, 8'h00, 1);
      vt[11] = mk(0, 8'h00, 0, 0,  0, 5'd4, 1, 8'hA2, 1);
      vt[12] = mk(0, 8'h00, 0, 0,  1, 5'd3, 0, 8'h00, 1);
      vt[13] = mk(0, 8'h00, 1, 0,  1, 5'd3, 0, 8'h00, 1);
      vt[14] = mk(0, 8'h00, 0, 0,  1, 5'd3, 1, 8'hA3, 1);
      vt[15] = mk(0, 8'h00, 0, 0,  1, 5'd2, 0, 8'h00, 1);
      vt[16] = mk(0, 8'h00, 1, 0,  1, 5'd2, 0, 8'h00, 1);
      vt[17] = mk(0, 8'h00, 0, 0,  1, 5'd2, 1, 8'hA4, 1);
      vt[18] = mk(0, 8'h00, 0, 0,  1, 5'd1, 0, 8'h00, 1);
      vt[19] = mk(0, 8'h00, 1, 0,  1, 5'd1, 0, 8'h00, 1);
      vt[20] = mk(0, 8'h00, 0, 0,  1, 5'd1, 1, 8'hA5, 1);
      vt[21] = mk(0, 8'h00, 0, 0,  1, 5'd0, 0, 8'h00, 1);
      vt[22] = mk(0, 8'h00, 1, 0,  1, 5'd0, 0, 8'h00, 1);
      vt[23] = mk(0, 8'h00, 0, 0,  1, 5'd0, 0, 8'h00, 1);
      for (int i = 0; i < 24; i++) begin
         bus.valid0  = vt[i].v0;
         bus.char0   = vt[i].c0;
         bus.tx_done = vt[i].done;
         clear_flag  = vt[i].clr;
         tick();
         chk($sformatf("tbl%0d_ready0", i),  32'(bus.ready0),   32'(vt[i].e_rdy0));
         chk($sformatf("tbl%0d_count", i),   32'(fifo_count),   32'(vt[i].e_cnt));
         chk($sformatf("tbl%0d_tx_load", i), 32'(bus.tx_load),  32'(vt[i].e_load));
         chk($sformatf("tbl%0d_pflag", i),   32'(printer_flag), 32'(vt[i].e_pf));
         if (vt[i].e_load) chk($sformatf("tbl%0d_tx_char", i), 32'(bus.tx_char), 32'(vt[i].e_char));
      end
      idle_inputs();

      // ---------------- in-order CPU characters, done 20 cycles after each load ----------------
      do_reset();
      push_q = '{8'h41, 8'h42, 8'h43};
      serve(120, 20, -1, 8'h00);
      chk("seq_loads",     32'(n_loads),  32'(3));
      chk("seq_char0",     32'(ld_char[0]), 32'h41);
      chk("seq_char1",     32'(ld_char[1]), 32'h42);
      chk("seq_char2",     32'(ld_char[2]), 32'h43);
      chk("seq_pf_first",  32'(ld_pf[0]),  32'(0));
      chk("seq_pf_second", 32'(ld_pf[1]),  32'(1));
      chk("seq_one_cycle", 32'(n_double), 32'(0));

      // ---------------- round-robin between FIFO and monitor ----------------
      do_reset();
      push_q = '{8'h10, 8'h11};
      serve(80, 3, 1, 8'h7E);
      chk("rr_loads",  32'(n_loads),    32'(3));
      chk("rr_char0",  32'(ld_char[0]), 32'h10);
      chk("rr_char1",  32'(ld_char[1]), 32'h7E);
      chk("rr_char2",  32'(ld_char[2]), 32'h11);
      chk("rr_ready1", 32'(n_rdy1),     32'(1));

      // ---------------- watchdog timeout ----------------
      do_reset();
      bus.valid0 = 1'b1; bus.char0 = 8'h20; tick();
      bus.char0 = 8'h21; tick();
      bus.valid0 = 1'b0;
      for (int i = 0; i < 10 && !bus.tx_load; i++) tick();
      chk("tmo_first_load", 32'(bus.tx_load), 32'(1));
      chk("tmo_first_char", 32'(bus.tx_char), 32'h20);
      loads = 0;
      for (int i = 0; i < TMO; i++) begin
         tick();
         if (bus.tx_load) loads++;
      end
      chk("tmo_no_load_in_wait", 32'(loads),       32'(0));
      chk("tmo_err_before",      32'(timeout_err), 32'(0));
      tick();
      chk("tmo_err_set",  32'(timeout_err),  32'(1));
      chk("tmo_pf_clear", 32'(printer_flag), 32'(0));
      chk("tmo_idle",     32'(bus.tx_load),  32'(0));
      tick();
      chk("tmo_next_load", 32'(bus.tx_load), 32'(1));
      chk("tmo_next_char", 32'(bus.tx_char), 32'h21);
      tick();
      bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
      chk("tmo_pf_after_done", 32'(printer_flag), 32'(1));
      chk("tmo_err_sticky",    32'(timeout_err),  32'(1));

      // ---------------- flush during WAIT with three entries queued ----------------
      for (int i = 0; i < 4; i++) begin
         bus.valid0 = 1'b1;
         bus.char0  = 8'(8'h30 + i);
         tick();
      end
      bus.valid0 = 1'b0;
      chk("fl_pre_count", 32'(fifo_count),   32'(3));
      chk("fl_pre_pf",    32'(printer_flag), 32'(1));
      flush = 1'b1; bus.valid0 = 1'b1; bus.char0 = 8'h99;
      tick();
      flush = 1'b0; bus.valid0 = 1'b0;
      chk("fl_count",  32'(fifo_count),   32'(0));
      chk("fl_pf",     32'(printer_flag), 32'(0));
      chk("fl_err",    32'(timeout_err),  32'(0));
      chk("fl_ready0", 32'(bus.ready0),   32'(1));
      tick();
      bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
      chk("fl_late_done_pf", 32'(printer_flag), 32'(0));
      loads = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.tx_load) loads++;
      end
      chk("fl_no_loads", 32'(loads), 32'(0));
      bus.valid0 = 1'b1; bus.char0 = 8'h55; tick();
      bus.valid0 = 1'b0; tick();
      chk("fl_restart_load", 32'(bus.tx_load), 32'(1));
      chk("fl_restart_char", 32'(bus.tx_char), 32'h55);

      // ---------------- randomized run against the reference model ----------------
      do_reset();
      model_reset();
      v1_on = 1'b0;
      for (int cyc = 0; cyc < 3000 && errors < 40; cyc++) begin
         chk("rnd_ready0",  32'(bus.ready0),   32'(m_q.size() < DEPTH));
         chk("rnd_count",   32'(fifo_count),   32'(m_q.size()));
         chk("rnd_tx_load", 32'(bus.tx_load),  32'(m_age == 0));
         chk("rnd_ready1",  32'(bus.ready1),   32'(m_age == 0 && m_g1));
         chk("rnd_pflag",   32'(printer_flag), 32'(m_pf));
         chk("rnd_tmo_err", 32'(timeout_err),  32'(m_te));
         if (m_age == 0) chk("rnd_tx_char", 32'(bus.tx_char), 32'(m_char));

         if (v1_on && bus.ready1)                    v1_on = 1'b0;
         else if (v1_on && $urandom_range(49) == 0)  v1_on = 1'b0;
         else if (!v1_on && $urandom_range(3) == 0) begin
            v1_on     = 1'b1;
            bus.char1 = 8'($urandom);
         end
         bus.valid1  = v1_on;
         bus.valid0  = ($urandom_range(1) == 1);
         bus.char0   = 8'($urandom);
         quiet       = cyc % 1000;
         bus.tx_done = !(quiet >= 500 && quiet < 800) && ($urandom_range(7) == 0);
         clear_flag  = ($urandom_range(9) == 0);
         flush       = ($urandom_range(199) == 0);
         model_step();
         tick();
      end
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
